// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared constants, state codes and address helper for the imem loader
//   Contents: state codes ST_HDR/ST_DATA/ST_DONE/ST_ERR, HDR_BYTES, WORD_BYTES, word_addr()
package imem_loader_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_HDR  = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   localparam int HDR_BYTES  = 4;
   localparam int WORD_BYTES = 4;

   // Byte address of word idx in an image placed at base.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and imem write bus of the imem loader
//   in_valid/in_data/in_ready : byte stream, transfer = in_valid & in_ready
//   imem_we/imem_addr/imem_wdata : single-cycle word write into imem
//   master : stream source / imem observer side
//   slave  : loader side (stream sink, imem writer)
interface imem_loader_if;

   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles accepted bytes into little-endian words
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear of lane counter and held bytes
//   fire        : a byte is accepted this cycle
//   din         : accepted byte
//   word        : assembled word, meaningful while word_valid is high
//   word_valid  : one-cycle pulse in the cycle the last lane is accepted
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    fire,
   input  logic [7:0]              din,
   output logic [8*WORD_BYTES-1:0] word,
   output logic                    word_valid
);

   localparam int              LW   = $clog2(WORD_BYTES);
   localparam logic [LW-1:0]   LAST = LW'(WORD_BYTES - 1);

   logic [LW-1:0] lane;
   logic [7:0]    lanes [WORD_BYTES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane <= '0;
         for (int i = 0; i < WORD_BYTES - 1; i++) lanes[i] <= '0;
      end else if (clr) begin
         lane <= '0;
         for (int i = 0; i < WORD_BYTES - 1; i++) lanes[i] <= '0;
      end else if (fire) begin
         for (int i = 0; i < WORD_BYTES - 1; i++)
            if (lane == LW'(i)) lanes[i] <= din;
         lane <= lane + LW'(1);
      end
   end

   // The top byte is taken straight from the stream so the word is
   // available on the same edge that accepts it; the caller registers it.
   always_comb begin
      word = '0;
      word[8*WORD_BYTES-1 -: 8] = din;
      for (int i = 0; i < WORD_BYTES - 1; i++) word[8*i +: 8] = lanes[i];
   end

   assign word_valid = fire && (lane == LAST);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a length-prefixed byte image into imem and holds the core in reset
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : imem_loader_if.slave (byte stream in, imem write out)
//   start       : re-arm a load, honoured in DONE or ERR only
//   cpu_rst_n   : core reset, released only once the image is complete
//   busy        : header or data phase in progress
//   done        : image fully written
//   err         : header word count larger than imem
//   word_count  : words written so far
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0
)(
   input  logic            clk,
   input  logic            rst_n,
   imem_loader_if.slave    bus,
   input  logic            start,
   output logic            cpu_rst_n,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [ADDR_W:0] word_count
);

   localparam logic [8*HDR_BYTES:0] MAX_WORDS = (8*HDR_BYTES+1)'(1) << ADDR_W;
   localparam logic [ADDR_W:0]      ONE       = (ADDR_W+1)'(1);

   state_t          state;
   logic            in_ready_q;
   logic            we_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [ADDR_W:0] hdr_n;

   logic                    fire;
   logic                    rearm;
   logic [8*WORD_BYTES-1:0] pk_word;
   logic                    pk_valid;
   logic [8*HDR_BYTES-1:0]  hdr_word;

   assign fire     = bus.in_valid & in_ready_q;
   assign rearm    = start & ((state == ST_DONE) | (state == ST_ERR));
   assign hdr_word = pk_word[8*HDR_BYTES-1:0];

   // One packer serves both phases: the header ends on a lane wrap, so
   // the first data byte always lands in lane 0.
   byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (rearm),
      .fire       (fire),
      .din        (bus.in_data),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_HDR;
         in_ready_q <= 1'b1;
         busy       <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
         hdr_n      <= '0;
      end else begin
         we_q <= 1'b0;
         case (state)
            ST_HDR: begin
               if (pk_valid) begin
                  if (hdr_word == '0) begin
                     state      <= ST_DONE;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     cpu_rst_n  <= 1'b1;
                  end else if ({1'b0, hdr_word} > MAX_WORDS) begin
                     state      <= ST_ERR;
                     in_ready_q <= 1'b0;
                     busy       <= 1'b0;
                     err        <= 1'b1;
                  end else begin
                     state <= ST_DATA;
                     hdr_n <= hdr_word[ADDR_W:0];
                  end
               end
            end
            ST_DATA: begin
               if (pk_valid) begin
                  we_q       <= 1'b1;
                  addr_q     <= word_addr(BASE_ADDR, 32'(word_count));
                  wdata_q    <= pk_word;
                  word_count <= word_count + ONE;
                  // Stop accepting once the last word is in, so bytes
                  // trailing the image stay in the stream.
                  if (word_count + ONE == hdr_n) in_ready_q <= 1'b0;
               end else if (we_q && (word_count == hdr_n)) begin
                  // Edge that ends the final strobe.
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_rst_n <= 1'b1;
               end
            end
            ST_DONE, ST_ERR: begin
               if (start) begin
                  state      <= ST_HDR;
                  in_ready_q <= 1'b1;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  cpu_rst_n  <= 1'b0;
                  word_count <= '0;
                  hdr_n      <= '0;
                  addr_q     <= BASE_ADDR;
               end
            end
            default: state <= ST_HDR;
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader (two parameter sets)
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       tb_valid = 1'b0;
   logic       tb_start = 1'b0;
   logic [7:0] tb_data = 8'h00;
   logic       sel = 1'b0;

   imem_loader_if if0 ();
   imem_loader_if if1 ();

   logic       cr0, cr1, busy0, busy1, done0, done1, err0, err1;
   logic [8:0] wc0;
   logic [3:0] wc1;

   assign if0.in_valid = tb_valid & ~sel;
   assign if1.in_valid = tb_valid & sel;
   assign if0.in_data  = tb_data;
   assign if1.in_data  = tb_data;

   imem_loader #(.ADDR_W(8), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(if0), .start(tb_start & ~sel),
      .cpu_rst_n(cr0), .busy(busy0), .done(done0), .err(err0), .word_count(wc0)
   );

   imem_loader #(.ADDR_W(3), .BASE_ADDR(32'h100)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(if1), .start(tb_start & sel),
      .cpu_rst_n(cr1), .busy(busy1), .done(done1), .err(err1), .word_count(wc1)
   );

   logic        o_we, o_ready, o_cpu, o_busy, o_done, o_err;
   logic [31:0] o_addr, o_wdata;
   logic [8:0]  o_wc;
   assign o_we    = sel ? if1.imem_we    : if0.imem_we;
   assign o_ready = sel ? if1.in_ready   : if0.in_ready;
   assign o_addr  = sel ? if1.imem_addr  : if0.imem_addr;
   assign o_wdata = sel ? if1.imem_wdata : if0.imem_wdata;
   assign o_cpu   = sel ? cr1   : cr0;
   assign o_busy  = sel ? busy1 : busy0;
   assign o_done  = sel ? done1 : done0;
   assign o_err   = sel ? err1  : err0;
   assign o_wc    = sel ? {5'd0, wc1} : wc0;

   logic [7:0]  stream_q [$];
   logic [31:0] wq [$];
   logic [63:0] got_q [$];

   always @(negedge clk) if (o_we) got_q.push_back({o_addr, o_wdata});

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) stream_q.push_back(w[8*i +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; tb_valid = 1'b0; tb_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drives stream_q; returns just after the edge that took the last byte.
   task automatic send(input bit gap);
      int idx = 0;
      int cyc = 0;
      bit fire_now;
      while (idx < stream_q.size() && cyc < 4*stream_q.size() + 40) begin
         @(negedge clk);
         tb_valid = gap ? (cyc % 2 == 0) : 1'b1;
         tb_data  = stream_q[idx];
         fire_now = tb_valid && o_ready;
         @(posedge clk);
         if (fire_now) idx++;
         cyc++;
      end
      chk("bytes_taken", idx, stream_q.size());
   endtask

   task automatic settle();
      int k = 0;
      @(negedge clk);
      tb_valid = 1'b0;
      while (!(o_done || o_err) && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("settle_in_time", k < 20, 1);
   endtask

   // Reference: word i of the image lands at base + 4*i, in order.
   task automatic expect_writes(input string tag, input logic [31:0] base);
      chk({tag, "_nwrites"}, got_q.size(), wq.size());
      for (int i = 0; i < wq.size() && i < got_q.size(); i++)
         chk({tag, "_write"}, got_q[i], {base + 32'(4*i), wq[i]});
   endtask

   task automatic check_reset(input string tag, input logic [31:0] base);
      chk({tag, "_we"},    o_we,    0);
      chk({tag, "_addr"},  o_addr,  base);
      chk({tag, "_wdata"}, o_wdata, 0);
      chk({tag, "_cpu"},   o_cpu,   0);
      chk({tag, "_done"},  o_done,  0);
      chk({tag, "_err"},   o_err,   0);
      chk({tag, "_wc"},    o_wc,    0);
      chk({tag, "_ready"}, o_ready, 1);
      chk({tag, "_busy"},  o_busy,  1);
   endtask

   task automatic load_t1();
      stream_q.delete(); wq.delete(); got_q.delete();
      wq.push_back(32'h00500013);
      wq.push_back(32'h00100093);
      push_word(32'd2);
      push_word(wq[0]);
      push_word(wq[1]);
   endtask

   typedef struct {
      int unsigned n;
      bit          sel;
      bit          gap;
      bit          exp_done;
      bit          exp_err;
      int unsigned exp_wc;
   } vec_t;

   vec_t tbl [8];

   initial begin
      tbl[0] = '{2,   1'b0, 1'b0, 1'b1, 1'b0, 2};
      tbl[1] = '{1,   1'b0, 1'b1, 1'b1, 1'b0, 1};
      tbl[2] = '{0,   1'b1, 1'b0, 1'b1, 1'b0, 0};
      tbl[3] = '{256, 1'b0, 1'b0, 1'b1, 1'b0, 256};
      tbl[4] = '{8,   1'b1, 1'b1, 1'b1, 1'b0, 8};
      tbl[5] = '{9,   1'b1, 1'b0, 1'b0, 1'b1, 0};
      tbl[6] = '{5,   1'b1, 1'b1, 1'b1, 1'b0, 5};
      tbl[7] = '{300, 1'b0, 1'b0, 1'b0, 1'b1, 0};

      // Reset values for both parameter sets.
      @(negedge clk);
      sel = 1'b0; #1 check_reset("rst0", 32'h0);
      sel = 1'b1; #1 check_reset("rst1", 32'h100);

      // Randomized images against the reference.
      for (int r = 0; r < 8; r++) begin
         int unsigned lim;
         logic [31:0] base;
         sel = tbl[r].sel;
         do_reset();
         lim  = sel ? 8 : 256;
         base = sel ? 32'h100 : 32'h0;
         stream_q.delete(); wq.delete(); got_q.delete();
         push_word(tbl[r].n);
         if (tbl[r].n <= lim)
            for (int i = 0; i < int'(tbl[r].n); i++) begin
               wq.push_back($urandom);
               push_word(wq[i]);
            end
         send(tbl[r].gap);
         settle();
         chk("row_done",  o_done,  tbl[r].exp_done);
         chk("row_err",   o_err,   tbl[r].exp_err);
         chk("row_wc",    o_wc,    tbl[r].exp_wc);
         chk("row_cpu",   o_cpu,   tbl[r].exp_done);
         chk("row_ready", o_ready, 0);
         expect_writes("row", base);
      end

      // Two-word image, continuous stream, exact strobe/done timing.
      sel = 1'b0;
      do_reset();
      load_t1();
      send(1'b0);
      @(negedge clk);
      tb_valid = 1'b0;
      chk("t1_we",      o_we,    1);
      chk("t1_addr",    o_addr,  32'h4);
      chk("t1_data",    o_wdata, 32'h00100093);
      chk("t1_early",   o_done,  0);
      @(negedge clk);
      chk("t1_done",    o_done,  1);
      chk("t1_cpu",     o_cpu,   1);
      chk("t1_wc",      o_wc,    2);
      chk("t1_we_off",  o_we,    0);
      expect_writes("t1", 32'h0);

      // Empty image.
      do_reset();
      stream_q.delete(); wq.delete(); got_q.delete();
      push_word(32'd0);
      send(1'b0);
      @(negedge clk);
      tb_valid = 1'b0;
      chk("t2_done", o_done, 1);
      chk("t2_cpu",  o_cpu,  1);
      repeat (3) @(negedge clk);
      expect_writes("t2", 32'h0);

      // Oversized header, then re-arm and load.
      do_reset();
      stream_q.delete(); wq.delete(); got_q.delete();
      push_word(32'd257);
      send(1'b0);
      settle();
      chk("t3_err",   o_err,   1);
      chk("t3_ready", o_ready, 0);
      chk("t3_cpu",   o_cpu,   0);
      tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      chk("t3_busy",   o_busy,  1);
      chk("t3_err_cl", o_err,   0);
      chk("t3_ready1", o_ready, 1);
      load_t1();
      send(1'b0);
      settle();
      expect_writes("t3", 32'h0);

      // Same image with gaps in the stream.
      do_reset();
      load_t1();
      send(1'b1);
      settle();
      chk("t4_wc", o_wc, 2);
      expect_writes("t4", 32'h0);

      // Reset after two bytes of word 0, then reload.
      do_reset();
      stream_q.delete(); got_q.delete();
      push_word(32'd2);
      stream_q.push_back(8'h13);
      stream_q.push_back(8'h00);
      send(1'b0);
      @(negedge clk);
      tb_valid = 1'b0;
      rst_n = 1'b0;
      #1 check_reset("t5", 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      load_t1();
      send(1'b0);
      settle();
      expect_writes("t5", 32'h0);

      // start during DATA is ignored; start in DONE re-arms at BASE 0x100.
      sel = 1'b1;
      do_reset();
      stream_q.delete(); wq.delete(); got_q.delete();
      wq.push_back($urandom);
      wq.push_back($urandom);
      push_word(32'd2);
      push_word(wq[0]);
      send(1'b0);
      @(negedge clk);
      tb_valid = 1'b0;
      tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      chk("t6_busy", o_busy, 1);
      chk("t6_done", o_done, 0);
      stream_q.delete();
      push_word(wq[1]);
      send(1'b0);
      settle();
      chk("t6_wc", o_wc, 2);
      chk("t6_done2", o_done, 1);
      expect_writes("t6", 32'h100);
      @(negedge clk);
      tb_start = 1'b1;
      tb_valid = 1'b1;
      tb_data  = 8'h55;
      @(posedge clk);
      #1;
      chk("t6b_cpu",   o_cpu,   0);
      chk("t6b_done",  o_done,  0);
      chk("t6b_wc",    o_wc,    0);
      chk("t6b_ready", o_ready, 1);
      @(negedge clk);
      tb_start = 1'b0;
      tb_valid = 1'b0;
      stream_q.delete(); wq.delete(); got_q.delete();
      wq.push_back($urandom);
      push_word(32'd1);
      push_word(wq[0]);
      send(1'b0);
      settle();
      chk("t6b_wc1", o_wc, 1);
      expect_writes("t6b", 32'h100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
